// File: rtl/instruction_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, immediate formats
// and the ID/EX pipeline register layout.
package riscv_definitions;

    localparam int RV_XLEN = 32;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_FENCE  = 7'b0001111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } aluOp_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } immType_e;

    typedef struct packed {
        logic               valid;
        logic [RV_XLEN-1:0] pc;
        logic [RV_XLEN-1:0] rs1_data;
        logic [RV_XLEN-1:0] rs2_data;
        logic [RV_XLEN-1:0] imm;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [2:0]         funct3;
        aluOp_e             alu_op;
        logic [1:0]         alu_src_a;
        logic               alu_src_b;
        logic               mem_rd;
        logic               mem_wr;
        logic               reg_wr;
        logic               branch;
        logic               jump;
        logic               jalr;
        logic               illegal;
    } idEx_s;

    // Shared by OP and OP-IMM; alt selects the arithmetic variant of shift-right.
    function automatic aluOp_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decode_regfile.sv
// Architectural register file: two async read ports, one sync write port,
// write-through bypass on reads, x0 hardwired to zero.
module register_file #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
        if (raddr2 != '0) rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I ID stage: decode, register read, immediate generation, load-use
// hazard detection and the ID/EX pipeline register.
module instruction_decode
    import riscv_definitions::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic [31:0]     inst_id,
    input  logic [XLEN-1:0] pc_id,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            valid_ex,
    output logic [XLEN-1:0] pc_ex,
    output logic [XLEN-1:0] rs1_data_ex,
    output logic [XLEN-1:0] rs2_data_ex,
    output logic [XLEN-1:0] imm_ex,
    output logic [4:0]      rs1_ex,
    output logic [4:0]      rs2_ex,
    output logic [4:0]      rd_ex,
    output logic [2:0]      funct3_ex,
    output logic [3:0]      alu_op_ex,
    output logic [1:0]      alu_src_a_ex,
    output logic            alu_src_b_ex,
    output logic            mem_rd_ex,
    output logic            mem_wr_ex,
    output logic            reg_wr_ex,
    output logic            branch_ex,
    output logic            jump_ex,
    output logic            jalr_ex,
    output logic            illegal_ex
);

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    assign opcode = inst_id[6:0];
    assign funct3 = inst_id[14:12];
    assign funct7 = inst_id[31:25];

    logic            use_rs1, use_rs2, writes_rd, illegal;
    logic            alu_src_b, mem_rd, mem_wr, branch, jump, jalr;
    logic [1:0]      alu_src_a;
    aluOp_e          alu_op;
    immType_e        imm_type;
    logic [XLEN-1:0] imm;

    always_comb begin : decode
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        alu_op    = ALU_ADD;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        jalr      = 1'b0;
        imm_type  = IMM_NONE;
        case (opcode)
            OPC_LUI: begin
                writes_rd = 1'b1; alu_op = ALU_PASS_B; alu_src_a = 2'd2;
                alu_src_b = 1'b1; imm_type = IMM_U;
            end
            OPC_AUIPC: begin
                writes_rd = 1'b1; alu_src_a = 2'd1; alu_src_b = 1'b1; imm_type = IMM_U;
            end
            OPC_JAL: begin
                writes_rd = 1'b1; jump = 1'b1; alu_src_a = 2'd1;
                alu_src_b = 1'b1; imm_type = IMM_J;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1; writes_rd = 1'b1; jump = 1'b1; jalr = 1'b1;
                alu_src_b = 1'b1; imm_type = IMM_I;
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; branch = 1'b1;
                alu_op = ALU_SUB; imm_type = IMM_B;
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1; writes_rd = 1'b1; mem_rd = 1'b1;
                alu_src_b = 1'b1; imm_type = IMM_I;
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; mem_wr = 1'b1;
                alu_src_b = 1'b1; imm_type = IMM_S;
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1; writes_rd = 1'b1; alu_src_b = 1'b1; imm_type = IMM_I;
                alu_op = alu_from_funct3(funct3, funct7[5]);
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    illegal = 1'b1;
            end
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
                if (funct7 == 7'b0000000)
                    alu_op = alu_from_funct3(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && funct3 == 3'b000)
                    alu_op = ALU_SUB;
                else if (funct7 == 7'b0100000 && funct3 == 3'b101)
                    alu_op = ALU_SRA;
                else
                    illegal = 1'b1;
            end
            OPC_FENCE: ;
            default: illegal = 1'b1;
        endcase
        // An illegal instruction reaches EX only to trap: no operands, no side effects.
        if (illegal) begin
            use_rs1   = 1'b0; use_rs2 = 1'b0; writes_rd = 1'b0;
            alu_op    = ALU_ADD; alu_src_a = 2'd0; alu_src_b = 1'b0;
            mem_rd    = 1'b0; mem_wr = 1'b0; branch = 1'b0;
            jump      = 1'b0; jalr = 1'b0; imm_type = IMM_NONE;
        end
    end

    always_comb begin : imm_gen
        case (imm_type)
            IMM_I:   imm = {{20{inst_id[31]}}, inst_id[31:20]};
            IMM_S:   imm = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
            IMM_B:   imm = {{19{inst_id[31]}}, inst_id[31], inst_id[7], inst_id[30:25],
                            inst_id[11:8], 1'b0};
            IMM_U:   imm = {inst_id[31:12], 12'b0};
            IMM_J:   imm = {{11{inst_id[31]}}, inst_id[31], inst_id[19:12], inst_id[20],
                            inst_id[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // Unused source fields read as x0 so forwarding never matches on stray bits.
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    assign rs1_addr = use_rs1   ? inst_id[19:15] : 5'd0;
    assign rs2_addr = use_rs2   ? inst_id[24:20] : 5'd0;
    assign rd_addr  = writes_rd ? inst_id[11:7]  : 5'd0;

    register_file #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .AW(5)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (clk_en & wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1_addr),
        .rdata1 (rs1_data),
        .raddr2 (rs2_addr),
        .rdata2 (rs2_data)
    );

    idEx_s id_ex, id_ex_d;

    assign stall = ~flush & id_ex.mem_rd & id_ex.valid & (id_ex.rd != 5'd0) &
                   ((use_rs1 & (rs1_addr == id_ex.rd)) | (use_rs2 & (rs2_addr == id_ex.rd)));

    always_comb begin : id_ex_next
        id_ex_d = '0;
        if (inst_id != 32'h0) begin
            id_ex_d.valid     = 1'b1;
            id_ex_d.pc        = pc_id;
            id_ex_d.rs1_data  = rs1_data;
            id_ex_d.rs2_data  = rs2_data;
            id_ex_d.imm       = imm;
            id_ex_d.rs1       = rs1_addr;
            id_ex_d.rs2       = rs2_addr;
            id_ex_d.rd        = rd_addr;
            id_ex_d.funct3    = funct3;
            id_ex_d.alu_op    = alu_op;
            id_ex_d.alu_src_a = alu_src_a;
            id_ex_d.alu_src_b = alu_src_b;
            id_ex_d.mem_rd    = mem_rd;
            id_ex_d.mem_wr    = mem_wr;
            id_ex_d.reg_wr    = writes_rd & (rd_addr != 5'd0);
            id_ex_d.branch    = branch;
            id_ex_d.jump      = jump;
            id_ex_d.jalr      = jalr;
            id_ex_d.illegal   = illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            id_ex <= '0;
        else if (clk_en)
            id_ex <= (flush || stall) ? '0 : id_ex_d;
    end

    assign valid_ex     = id_ex.valid;
    assign pc_ex        = id_ex.pc;
    assign rs1_data_ex  = id_ex.rs1_data;
    assign rs2_data_ex  = id_ex.rs2_data;
    assign imm_ex       = id_ex.imm;
    assign rs1_ex       = id_ex.rs1;
    assign rs2_ex       = id_ex.rs2;
    assign rd_ex        = id_ex.rd;
    assign funct3_ex    = id_ex.funct3;
    assign alu_op_ex    = id_ex.alu_op;
    assign alu_src_a_ex = id_ex.alu_src_a;
    assign alu_src_b_ex = id_ex.alu_src_b;
    assign mem_rd_ex    = id_ex.mem_rd;
    assign mem_wr_ex    = id_ex.mem_wr;
    assign reg_wr_ex    = id_ex.reg_wr;
    assign branch_ex    = id_ex.branch;
    assign jump_ex      = id_ex.jump;
    assign jalr_ex      = id_ex.jalr;
    assign illegal_ex   = id_ex.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: decode vector table, hazard/flush/enable/reset
// sequences, then random instructions checked against a behavioural model.
module tb_instruction_decode;
    import riscv_definitions::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clk_en, flush, wb_en, stall;
    logic [31:0] inst_id, pc_id, wb_data;
    logic [4:0]  wb_addr;
    logic        valid_ex, alu_src_b_ex, mem_rd_ex, mem_wr_ex, reg_wr_ex;
    logic        branch_ex, jump_ex, jalr_ex, illegal_ex;
    logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic [2:0]  funct3_ex;
    logic [3:0]  alu_op_ex;
    logic [1:0]  alu_src_a_ex;

    instruction_decode dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .inst_id(inst_id), .pc_id(pc_id),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall), .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex),
        .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .funct3_ex(funct3_ex), .alu_op_ex(alu_op_ex),
        .alu_src_a_ex(alu_src_a_ex), .alu_src_b_ex(alu_src_b_ex), .mem_rd_ex(mem_rd_ex),
        .mem_wr_ex(mem_wr_ex), .reg_wr_ex(reg_wr_ex), .branch_ex(branch_ex),
        .jump_ex(jump_ex), .jalr_ex(jalr_ex), .illegal_ex(illegal_ex)
    );

    typedef struct packed {
        logic [31:0] pc, d1, d2, imm;
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [1:0]  sa;
        logic        sb, mr, mw, rw, br, jp, jr, il;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst;
        exp_t        e;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    logic [31:0] mregs [32];

    logic [32:0] dut_ctl;
    assign dut_ctl = {valid_ex, rs1_ex, rs2_ex, rd_ex, funct3_ex, alu_op_ex, alu_src_a_ex,
                      alu_src_b_ex, mem_rd_ex, mem_wr_ex, reg_wr_ex, branch_ex, jump_ex,
                      jalr_ex, illegal_ex};

    function automatic logic [32:0] ctl_of(input exp_t e);
        return {e.v, e.rs1, e.rs2, e.rd, e.f3, e.alu, e.sa, e.sb, e.mr, e.mw, e.rw,
                e.br, e.jp, e.jr, e.il};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e);
        chk({tag, ".ctl"}, dut_ctl, ctl_of(e));
        chk({tag, ".pc"}, pc_ex, e.pc);
        chk({tag, ".rs1d"}, rs1_data_ex, e.d1);
        chk({tag, ".rs2d"}, rs2_data_ex, e.d2);
        chk({tag, ".imm"}, imm_ex, e.imm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags = {alu_src_b, mem_rd, mem_wr, reg_wr, branch, jump, jalr, illegal}
    function automatic exp_t ex(input logic [4:0] rs1, rs2, rd, input logic [2:0] f3,
                                input logic [3:0] alu, input logic [1:0] sa,
                                input logic [7:0] flags, input logic [31:0] imm);
        exp_t e = '0;
        e.v = 1'b1; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.f3 = f3; e.alu = alu;
        e.sa = sa; {e.sb, e.mr, e.mw, e.rw, e.br, e.jp, e.jr, e.il} = flags; e.imm = imm;
        return e;
    endfunction

    // Reference decode written from the ISA rules; register data filled in by the caller.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e = '0;
        logic u1 = 0, u2 = 0, wr = 0, bad = 0;
        logic [3:0] amap [8];
        amap = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (i == 32'h0) return e;
        e.v = 1; e.pc = pc; e.f3 = i[14:12];
        case (i[6:0])
            7'h37: begin e.imm = i & 32'hFFFFF000; e.alu = ALU_PASS_B; e.sa = 2; e.sb = 1; wr = 1; end
            7'h17: begin e.imm = i & 32'hFFFFF000; e.sa = 1; e.sb = 1; wr = 1; end
            7'h6F: begin
                e.imm = (32'($signed(i) >>> 31) << 20) | (32'(i[19:12]) << 12) |
                        (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
                e.sa = 1; e.sb = 1; e.jp = 1; wr = 1;
            end
            7'h67: begin e.imm = 32'($signed(i) >>> 20); u1 = 1; e.sb = 1; e.jp = 1; e.jr = 1; wr = 1; end
            7'h63: begin
                e.imm = (32'($signed(i) >>> 31) << 12) | (32'(i[7]) << 11) |
                        (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
                u1 = 1; u2 = 1; e.br = 1; e.alu = ALU_SUB;
            end
            7'h03: begin e.imm = 32'($signed(i) >>> 20); u1 = 1; e.sb = 1; e.mr = 1; wr = 1; end
            7'h23: begin
                e.imm = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
                u1 = 1; u2 = 1; e.sb = 1; e.mw = 1;
            end
            7'h13: begin
                e.imm = 32'($signed(i) >>> 20); u1 = 1; e.sb = 1; wr = 1;
                e.alu = amap[i[14:12]];
                if (i[14:12] == 5) begin
                    if (i[31:25] == 7'h20) e.alu = ALU_SRA;
                    else if (i[31:25] != 0) bad = 1;
                end
            end
            7'h33: begin
                u1 = 1; u2 = 1; wr = 1;
                if (i[31:25] == 0) e.alu = amap[i[14:12]];
                else if (i[31:25] == 7'h20 && i[14:12] == 0) e.alu = ALU_SUB;
                else if (i[31:25] == 7'h20 && i[14:12] == 5) e.alu = ALU_SRA;
                else bad = 1;
            end
            7'h0F: ;
            default: bad = 1;
        endcase
        if (bad) begin
            e = '0; e.v = 1; e.il = 1; e.pc = pc; e.f3 = i[14:12];
            return e;
        end
        e.rs1 = u1 ? i[19:15] : 5'd0;
        e.rs2 = u2 ? i[24:20] : 5'd0;
        e.rd  = wr ? i[11:7]  : 5'd0;
        e.rw  = wr && i[11:7] != 0;
        return e;
    endfunction

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [12];
        logic [31:0] i = $urandom;
        int r;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        r = $urandom_range(0, 12);
        if (r < 12) i[6:0] = ops[r];
        i[11:7] = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        if (i[6:0] == 7'h33 || i[6:0] == 7'h13) begin
            r = $urandom_range(0, 9);
            if (r < 6) i[31:25] = 7'h00;
            else if (r < 9) i[31:25] = 7'h20;
        end
        if ($urandom_range(0, 29) == 0) i = 32'h0;
        return i;
    endfunction

    vec_t tbl [19];
    exp_t e, cur_exp;

    initial begin
        tbl = '{
            '{32'h00500093, ex(0, 0, 1, 0, ALU_ADD, 0, 8'b1001_0000, 32'h5)},
            '{32'h123452B7, ex(0, 0, 5, 5, ALU_PASS_B, 2, 8'b1001_0000, 32'h12345000)},
            '{32'hFFFFF317, ex(0, 0, 6, 7, ALU_ADD, 1, 8'b1001_0000, 32'hFFFFF000)},
            '{32'hFF9FF0EF, ex(0, 0, 1, 7, ALU_ADD, 1, 8'b1001_0100, 32'hFFFFFFF8)},
            '{32'h00008067, ex(1, 0, 0, 0, ALU_ADD, 0, 8'b1000_0110, 32'h0)},
            '{32'hFE000EE3, ex(0, 0, 0, 0, ALU_SUB, 0, 8'b0000_1000, 32'hFFFFFFFC)},
            '{32'h0000A283, ex(1, 0, 5, 2, ALU_ADD, 0, 8'b1101_0000, 32'h0)},
            '{32'h00712423, ex(2, 7, 0, 2, ALU_ADD, 0, 8'b1010_0000, 32'h8)},
            '{32'h40225193, ex(4, 0, 3, 5, ALU_SRA, 0, 8'b1001_0000, 32'h402)},
            '{32'h20225193, ex(0, 0, 0, 5, ALU_ADD, 0, 8'b0000_0001, 32'h0)},
            '{32'h402081B3, ex(1, 2, 3, 0, ALU_SUB, 0, 8'b0001_0000, 32'h0)},
            '{32'h022081B3, ex(0, 0, 0, 0, ALU_ADD, 0, 8'b0000_0001, 32'h0)},
            '{32'h00000073, ex(0, 0, 0, 0, ALU_ADD, 0, 8'b0000_0001, 32'h0)},
            '{32'h0000000F, ex(0, 0, 0, 0, ALU_ADD, 0, 8'b0000_0000, 32'h0)},
            '{32'h00000000, exp_t'('0)},
            '{32'h00B534B3, ex(10, 11, 9, 3, ALU_SLTU, 0, 8'b0001_0000, 32'h0)},
            '{32'hFFF4C413, ex(9, 0, 8, 4, ALU_XOR, 0, 8'b1001_0000, 32'hFFFFFFFF)},
            '{32'h00000013, ex(0, 0, 0, 0, ALU_ADD, 0, 8'b1000_0000, 32'h0)},
            '{32'h0000007F, ex(0, 0, 0, 0, ALU_ADD, 0, 8'b0000_0001, 32'h0)}
        };

        rst = 1; clk_en = 1; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        inst_id = 0; pc_id = 0;
        step(); step();
        rst = 0;
        cmp("reset", exp_t'('0));
        chk("reset.stall", stall, 0);

        // Decode table, register file all zero
        foreach (tbl[k]) begin
            inst_id = tbl[k].inst; pc_id = 32'h10 + 32'(k) * 4;
            e = tbl[k].e;
            if (e.v) e.pc = pc_id;
            #1 chk($sformatf("tbl%0d.stall", k), stall, 0);
            step();
            cmp($sformatf("tbl%0d", k), e);
        end

        // Write-through bypass, then the stored value, then x0 writes ignored
        inst_id = 32'h002101B3; pc_id = 32'h100;
        wb_en = 1; wb_addr = 2; wb_data = 32'hDEADBEEF;
        step();
        e = ex(2, 2, 3, 0, ALU_ADD, 0, 8'b0001_0000, 0); e.pc = 32'h100;
        e.d1 = 32'hDEADBEEF; e.d2 = 32'hDEADBEEF;
        cmp("bypass", e);
        wb_en = 0; pc_id = 32'h104;
        step();
        e.pc = 32'h104;
        cmp("stored", e);
        inst_id = 32'h000001B3; wb_en = 1; wb_addr = 0; wb_data = 32'h5;
        step();
        chk("x0.rs1d", rs1_data_ex, 0);
        wb_en = 0;

        // Load-use on rs1/rs2
        inst_id = 32'h0000A283; step();
        inst_id = 32'h00728333;
        #1 chk("lu.stall", stall, 1);
        step();
        chk("lu.bubble", valid_ex, 0);
        chk("lu.stall_clear", stall, 0);
        pc_id = 32'h200;
        step();
        e = ex(5, 7, 6, 0, ALU_ADD, 0, 8'b0001_0000, 0); e.pc = 32'h200;
        cmp("lu.issue", e);
        inst_id = 32'h0000A283; step();
        inst_id = 32'h00512423;
        #1 chk("lu_rs2.stall", stall, 1);
        step(); step();
        inst_id = 32'h0000A283; step();
        inst_id = 32'h00508313;
        #1 chk("lu_unused_rs2.stall", stall, 0);
        inst_id = 32'h0000A003; step();
        inst_id = 32'h00700333;
        #1 chk("lu_x0.stall", stall, 0);

        // Flush while a stall would be raised
        inst_id = 32'h0000A283; step();
        inst_id = 32'h00728333; flush = 1;
        #1 chk("flush.stall", stall, 0);
        step();
        chk("flush.bubble", valid_ex, 0);
        flush = 0;
        step();
        chk("flush.after", valid_ex, 1);

        // Clock enable low freezes everything, including the register file write
        inst_id = 32'h00500093; pc_id = 32'h40;
        step();
        e = ex(0, 0, 1, 0, ALU_ADD, 0, 8'b1001_0000, 32'h5); e.pc = 32'h40;
        clk_en = 0; inst_id = 32'h402081B3; pc_id = 32'h44;
        wb_en = 1; wb_addr = 9; wb_data = 32'h55;
        for (int c = 0; c < 3; c++) begin
            step();
            cmp($sformatf("freeze%0d", c), e);
        end
        clk_en = 1; wb_en = 0; inst_id = 32'h000481B3;
        step();
        chk("freeze.nowrite", rs1_data_ex, 0);

        // Reset with clock enable low
        inst_id = 32'h00500093; wb_en = 1; wb_addr = 1; wb_data = 32'h1234;
        step();
        wb_en = 0; rst = 1; clk_en = 0;
        step();
        cmp("rst_mid", exp_t'('0));
        rst = 0; clk_en = 1; inst_id = 32'h00008113;
        step();
        chk("rst_mid.x1", rs1_data_ex, 0);

        // Random stream against the reference model
        rst = 1; inst_id = 0; step(); rst = 0;
        foreach (mregs[r]) mregs[r] = 0;
        cur_exp = '0;
        begin
            logic [31:0] ri = 0, rpc = 0;
            logic hold = 0, es;
            exp_t nxt;
            for (int k = 0; k < 600; k++) begin
                if (!hold) begin ri = rand_inst(); rpc = $urandom & 32'hFFFFFFFC; end
                clk_en = ($urandom_range(0, 9) != 0);
                flush = ($urandom_range(0, 9) == 0);
                wb_en = 1'($urandom_range(0, 1));
                wb_addr = 5'($urandom_range(0, 7));
                wb_data = $urandom;
                inst_id = ri; pc_id = rpc;
                e = model(ri, rpc);
                es = !flush && cur_exp.mr && cur_exp.v && cur_exp.rd != 0 &&
                     (e.rs1 == cur_exp.rd || e.rs2 == cur_exp.rd);
                #1 chk($sformatf("rnd%0d.stall", k), stall, es);
                if (clk_en) begin
                    if (flush || es || !e.v) nxt = '0;
                    else begin nxt = e; nxt.d1 = rdreg(e.rs1); nxt.d2 = rdreg(e.rs2); end
                    cur_exp = nxt;
                    if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
                end
                hold = es || !clk_en;
                step();
                cmp($sformatf("rnd%0d", k), cur_exp);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
